// File: rtl/axi_ram_burst_slave_if.sv
// AXI4 bus bundle for the burst RAM slave.
// Carries the five AXI channels used by the slave:
//   AW: aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_valid / aw_ready
//   W : w_data, w_strb, w_last, w_valid / w_ready
//   B : b_id, b_resp, b_valid / b_ready
//   AR: ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_valid / ar_ready
//   R : r_id, r_data, r_resp, r_last, r_valid / r_ready
// The master modport is the initiator side, the slave modport is the RAM side.
interface axi_ram_burst_slave_if #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 32,
    parameter int STRB_WIDTH = DATA_WIDTH / 8,
    parameter int ID_WIDTH   = 4
);
    logic [ID_WIDTH-1:0]   aw_id;
    logic [ADDR_WIDTH-1:0] aw_addr;
    logic [7:0]            aw_len;
    logic [2:0]            aw_size;
    logic [1:0]            aw_burst;
    logic                  aw_valid;
    logic                  aw_ready;

    logic [DATA_WIDTH-1:0] w_data;
    logic [STRB_WIDTH-1:0] w_strb;
    logic                  w_last;
    logic                  w_valid;
    logic                  w_ready;

    logic [ID_WIDTH-1:0]   b_id;
    logic [1:0]            b_resp;
    logic                  b_valid;
    logic                  b_ready;

    logic [ID_WIDTH-1:0]   ar_id;
    logic [ADDR_WIDTH-1:0] ar_addr;
    logic [7:0]            ar_len;
    logic [2:0]            ar_size;
    logic [1:0]            ar_burst;
    logic                  ar_valid;
    logic                  ar_ready;

    logic [ID_WIDTH-1:0]   r_id;
    logic [DATA_WIDTH-1:0] r_data;
    logic [1:0]            r_resp;
    logic                  r_last;
    logic                  r_valid;
    logic                  r_ready;

    modport master (
        output aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_valid,
        input  aw_ready,
        output w_data, w_strb, w_last, w_valid,
        input  w_ready,
        input  b_id, b_resp, b_valid,
        output b_ready,
        output ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_valid,
        input  ar_ready,
        input  r_id, r_data, r_resp, r_last, r_valid,
        output r_ready
    );

    modport slave (
        input  aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_valid,
        output aw_ready,
        input  w_data, w_strb, w_last, w_valid,
        output w_ready,
        output b_id, b_resp, b_valid,
        input  b_ready,
        input  ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_valid,
        output ar_ready,
        output r_id, r_data, r_resp, r_last, r_valid,
        input  r_ready
    );
endinterface

// File: rtl/axi_ram_burst_slave.sv
// AXI4 on-chip RAM target with FIXED / INCR / WRAP burst support.
// Independent write (AW/W/B) and read (AR/R) state machines, one outstanding
// transaction per direction. Out-of-range beats and illegal bursts answer
// SLVERR; out-of-range writes are dropped and out-of-range reads return zero.
// Ports:
//   clk  - rising-edge clock
//   rst  - asynchronous active-high reset (RAM contents are kept)
//   bus  - AXI4 slave modport (see axi_ram_burst_slave_if)
// DATA_WIDTH must be 8, 16, 32 or 64.
module axi_ram_burst_slave #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 32,
    parameter int STRB_WIDTH = DATA_WIDTH / 8,
    parameter int ID_WIDTH   = 4,
    parameter int MEM_DEPTH  = 256
) (
    input  logic                  clk,
    input  logic                  rst,
    axi_ram_burst_slave_if.slave  bus
);
    localparam int SHIFT  = $clog2(STRB_WIDTH);
    localparam int MEM_AW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;
    localparam logic [1:0] BURST_RSVD  = 2'b11;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = 1;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wr_state_t;
    typedef enum logic       {R_IDLE, R_DATA}         rd_state_t;

    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

    // Beats wider than the bus are narrowed to a full-width beat.
    function automatic logic [2:0] clamp_size(input logic [2:0] size);
        return (size > 3'(SHIFT)) ? 3'(SHIFT) : size;
    endfunction

    function automatic logic wrap_len_ok(input logic [7:0] len);
        return (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
    endfunction

    function automatic logic burst_illegal(input logic [1:0] burst, input logic [7:0] len);
        return (burst == BURST_RSVD) || ((burst == BURST_WRAP) && !wrap_len_ok(len));
    endfunction

    // Illegal WRAP lengths fall back to INCR, the reserved type to FIXED.
    function automatic logic [ADDR_WIDTH-1:0] next_addr(
        input logic [ADDR_WIDTH-1:0] addr,
        input logic [2:0]            size,
        input logic [7:0]            len,
        input logic [1:0]            burst
    );
        logic [ADDR_WIDTH-1:0] step;
        logic [ADDR_WIDTH-1:0] wrap_len;
        logic [ADDR_WIDTH-1:0] incr_addr;
        logic [ADDR_WIDTH-1:0] result;
        step      = ADDR_ONE << size;
        wrap_len  = ADDR_WIDTH'((32'(len) + 32'd1) << size);
        incr_addr = (addr & ~(step - ADDR_ONE)) + step;
        case (burst)
            BURST_INCR: result = incr_addr;
            BURST_WRAP: begin
                if (wrap_len_ok(len)) begin
                    result = (addr & ~(wrap_len - ADDR_ONE)) | ((addr + step) & (wrap_len - ADDR_ONE));
                end else begin
                    result = incr_addr;
                end
            end
            default: result = addr;
        endcase
        return result;
    endfunction

    function automatic logic in_range(input logic [ADDR_WIDTH-1:0] addr);
        return (64'(addr >> SHIFT) < 64'(MEM_DEPTH));
    endfunction

    function automatic logic [MEM_AW-1:0] word_of(input logic [ADDR_WIDTH-1:0] addr);
        return MEM_AW'(addr >> SHIFT);
    endfunction

    // ------------------------------------------------------------------
    // Write path
    // ------------------------------------------------------------------
    wr_state_t             wr_state;
    logic [ID_WIDTH-1:0]   wr_id;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [7:0]            wr_len;
    logic [2:0]            wr_size;
    logic [1:0]            wr_burst;
    logic [7:0]            wr_count;
    logic                  wr_err;

    logic                  wr_fire;
    logic                  wr_beat_ok;
    logic                  wr_last_beat;
    logic                  wr_beat_err;
    logic                  wr_mem_en;
    logic [MEM_AW-1:0]     wr_word;

    always_comb begin
        wr_fire      = bus.w_valid && bus.w_ready;
        wr_beat_ok   = in_range(wr_addr);
        wr_last_beat = (wr_count == 8'd0);
        wr_beat_err  = !wr_beat_ok || (bus.w_last != wr_last_beat);
        wr_mem_en    = wr_fire && wr_beat_ok;
        wr_word      = word_of(wr_addr);
    end

    // RAM has no reset so its contents survive a reset pulse.
    always_ff @(posedge clk) begin
        if (wr_mem_en) begin
            for (int b = 0; b < STRB_WIDTH; b++) begin
                if (bus.w_strb[b]) begin
                    mem[wr_word][8*b +: 8] <= bus.w_data[8*b +: 8];
                end
            end
        end
    end

    // Write FSM. The error flag starts with the burst-type check and then
    // accumulates per-beat range and w_last problems until the response.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_state     <= W_IDLE;
            bus.aw_ready <= 1'b0;
            bus.w_ready  <= 1'b0;
            bus.b_valid  <= 1'b0;
            bus.b_resp   <= RESP_OKAY;
            bus.b_id     <= '0;
            wr_id        <= '0;
            wr_addr      <= '0;
            wr_len       <= '0;
            wr_size      <= '0;
            wr_burst     <= BURST_FIXED;
            wr_count     <= '0;
            wr_err       <= 1'b0;
        end else begin
            case (wr_state)
                W_IDLE: begin
                    bus.aw_ready <= 1'b1;
                    if (bus.aw_valid && bus.aw_ready) begin
                        wr_id        <= bus.aw_id;
                        wr_addr      <= bus.aw_addr;
                        wr_len       <= bus.aw_len;
                        wr_size      <= clamp_size(bus.aw_size);
                        wr_burst     <= bus.aw_burst;
                        wr_count     <= bus.aw_len;
                        wr_err       <= burst_illegal(bus.aw_burst, bus.aw_len);
                        bus.aw_ready <= 1'b0;
                        bus.w_ready  <= 1'b1;
                        wr_state     <= W_DATA;
                    end
                end
                W_DATA: begin
                    if (wr_fire) begin
                        wr_addr  <= next_addr(wr_addr, wr_size, wr_len, wr_burst);
                        wr_count <= wr_count - 8'd1;
                        wr_err   <= wr_err || wr_beat_err;
                        if (wr_last_beat) begin
                            bus.w_ready <= 1'b0;
                            bus.b_valid <= 1'b1;
                            bus.b_id    <= wr_id;
                            bus.b_resp  <= (wr_err || wr_beat_err) ? RESP_SLVERR : RESP_OKAY;
                            wr_state    <= W_RESP;
                        end
                    end
                end
                W_RESP: begin
                    if (bus.b_ready) begin
                        bus.b_valid  <= 1'b0;
                        bus.aw_ready <= 1'b1;
                        wr_state     <= W_IDLE;
                    end
                end
                default: wr_state <= W_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Read path
    // ------------------------------------------------------------------
    rd_state_t             rd_state;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic [7:0]            rd_len;
    logic [2:0]            rd_size;
    logic [1:0]            rd_burst;
    logic [7:0]            rd_count;
    logic                  rd_bad;

    logic [2:0]            ar_size_c;
    logic [ADDR_WIDTH-1:0] rd_src_addr;
    logic                  rd_src_bad;
    logic                  rd_src_ok;
    logic [DATA_WIDTH-1:0] rd_src_data;

    // The beat about to be presented comes straight from the AR channel at
    // the handshake, and from the latched next address afterwards. Sampling
    // the RAM on the same edge as a write yields the old word.
    always_comb begin
        ar_size_c   = clamp_size(bus.ar_size);
        rd_src_addr = (rd_state == R_IDLE) ? bus.ar_addr : rd_addr;
        rd_src_bad  = (rd_state == R_IDLE) ? burst_illegal(bus.ar_burst, bus.ar_len) : rd_bad;
        rd_src_ok   = in_range(rd_src_addr);
        rd_src_data = rd_src_ok ? mem[word_of(rd_src_addr)] : '0;
    end

    // Read FSM. rd_addr always holds the address of the next beat to load,
    // rd_count the number of beats still to follow the one on the bus.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_state     <= R_IDLE;
            bus.ar_ready <= 1'b0;
            bus.r_valid  <= 1'b0;
            bus.r_last   <= 1'b0;
            bus.r_resp   <= RESP_OKAY;
            bus.r_id     <= '0;
            bus.r_data   <= '0;
            rd_addr      <= '0;
            rd_len       <= '0;
            rd_size      <= '0;
            rd_burst     <= BURST_FIXED;
            rd_count     <= '0;
            rd_bad       <= 1'b0;
        end else begin
            case (rd_state)
                R_IDLE: begin
                    bus.ar_ready <= 1'b1;
                    if (bus.ar_valid && bus.ar_ready) begin
                        rd_len       <= bus.ar_len;
                        rd_size      <= ar_size_c;
                        rd_burst     <= bus.ar_burst;
                        rd_bad       <= rd_src_bad;
                        rd_count     <= bus.ar_len;
                        rd_addr      <= next_addr(bus.ar_addr, ar_size_c, bus.ar_len, bus.ar_burst);
                        bus.r_id     <= bus.ar_id;
                        bus.r_data   <= rd_src_data;
                        bus.r_resp   <= (rd_src_bad || !rd_src_ok) ? RESP_SLVERR : RESP_OKAY;
                        bus.r_last   <= (bus.ar_len == 8'd0);
                        bus.r_valid  <= 1'b1;
                        bus.ar_ready <= 1'b0;
                        rd_state     <= R_DATA;
                    end
                end
                R_DATA: begin
                    if (bus.r_valid && bus.r_ready) begin
                        if (rd_count == 8'd0) begin
                            bus.r_valid  <= 1'b0;
                            bus.r_last   <= 1'b0;
                            bus.ar_ready <= 1'b1;
                            rd_state     <= R_IDLE;
                        end else begin
                            bus.r_data <= rd_src_data;
                            bus.r_resp <= (rd_src_bad || !rd_src_ok) ? RESP_SLVERR : RESP_OKAY;
                            bus.r_last <= (rd_count == 8'd1);
                            rd_count   <= rd_count - 8'd1;
                            rd_addr    <= next_addr(rd_addr, rd_size, rd_len, rd_burst);
                        end
                    end
                end
                default: rd_state <= R_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_axi_ram_burst_slave.sv
// Testbench for axi_ram_burst_slave: directed bursts followed by random ones,
// checked by a scoreboard against a byte-level RAM model.
`timescale 1ns/1ps
module tb_axi_ram_burst_slave;
    localparam int ADDR_WIDTH = 12;
    localparam int DATA_WIDTH = 32;
    localparam int STRB_WIDTH = 4;
    localparam int ID_WIDTH   = 4;
    localparam int MEM_DEPTH  = 256;

    typedef struct packed {
        logic [3:0] id;
        logic [1:0] resp;
    } b_exp_t;

    typedef struct packed {
        logic [3:0]  id;
        logic [31:0] data;
        logic [1:0]  resp;
        logic        last;
    } r_exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;

    axi_ram_burst_slave_if #(
        .ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH),
        .STRB_WIDTH(STRB_WIDTH), .ID_WIDTH(ID_WIDTH)
    ) bus ();

    axi_ram_burst_slave #(
        .ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH), .STRB_WIDTH(STRB_WIDTH),
        .ID_WIDTH(ID_WIDTH), .MEM_DEPTH(MEM_DEPTH)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    logic [31:0] ref_mem [MEM_DEPTH];
    b_exp_t      b_q[$];
    r_exp_t      r_q[$];
    int          errors = 0;
    int          checks = 0;
    int          r_hs = 0;
    logic [31:0] wdata_tab [16];
    logic [3:0]  wstrb_tab [16];
    bit          rr_mode = 0;
    int          rr_idx = 0;
    logic [3:0]  rr_pat = 4'b1001;

    task automatic check_output(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic check_handshake(input string name, input bit ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("[TB] FAIL %s: got timeout, expected handshake", name);
        end
    endtask

    // Address of beat i of a burst, from the burst start and burst rules.
    function automatic int beat_addr(input int a0, input int i, input int size, input int len, input int burst);
        int s;
        int l;
        int base;
        int a_al;
        s    = 1 << ((size > 2) ? 2 : size);
        a_al = a0 - (a0 % s);
        if (i == 0 || burst == 0 || burst == 3) return a0;
        if (burst == 2 && (len inside {1, 3, 7, 15})) begin
            l    = (len + 1) * s;
            base = a0 - (a0 % l);
            return base + ((a_al - base + i * s) % l);
        end
        return (a_al + i * s) % 4096;
    endfunction

    function automatic bit burst_bad(input int burst, input int len);
        return (burst == 3) || (burst == 2 && !(len inside {1, 3, 7, 15}));
    endfunction

    task automatic write_burst(input int id, input int addr, input int len, input int size,
                               input int burst, input int early_last, input int abort_after);
        bit err;
        bit ok;
        int widx;
        err = burst_bad(burst, len) || (early_last >= 0 && early_last != len);
        for (int i = 0; i <= len; i++) begin
            if ((beat_addr(addr, i, size, len, burst) >> 2) >= MEM_DEPTH) err = 1;
        end
        if (abort_after < 0) b_q.push_back(b_exp_t'{4'(id), err ? 2'b10 : 2'b00});
        bus.aw_id    = 4'(id);
        bus.aw_addr  = 12'(addr);
        bus.aw_len   = 8'(len);
        bus.aw_size  = 3'(size);
        bus.aw_burst = 2'(burst);
        bus.aw_valid = 1'b1;
        ok = 0;
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            if (bus.aw_ready) begin ok = 1; break; end
        end
        check_handshake("aw_handshake", ok);
        @(posedge clk); #1;
        bus.aw_valid = 1'b0;
        for (int i = 0; i <= len; i++) begin
            if (abort_after >= 0 && i == abort_after) return;
            if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
            bus.w_data  = wdata_tab[i];
            bus.w_strb  = wstrb_tab[i];
            bus.w_last  = (i == len) || (i == early_last);
            bus.w_valid = 1'b1;
            ok = 0;
            for (int t = 0; t < 200; t++) begin
                @(negedge clk);
                if (bus.w_ready) begin ok = 1; break; end
            end
            check_handshake("w_handshake", ok);
            @(posedge clk); #1;
            bus.w_valid = 1'b0;
            bus.w_last  = 1'b0;
            widx = beat_addr(addr, i, size, len, burst) >> 2;
            if (widx < MEM_DEPTH) begin
                for (int b = 0; b < 4; b++) begin
                    if (wstrb_tab[i][b]) ref_mem[widx][8*b +: 8] = wdata_tab[i][8*b +: 8];
                end
            end
        end
        ok = 0;
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            if (b_q.size() == 0) begin ok = 1; break; end
        end
        check_handshake("b_response", ok);
        @(posedge clk); #1;
    endtask

    task automatic read_burst(input int id, input int addr, input int len, input int size, input int burst);
        bit     ok;
        bit     bad;
        int     widx;
        r_exp_t e;
        bad = burst_bad(burst, len);
        for (int i = 0; i <= len; i++) begin
            widx   = beat_addr(addr, i, size, len, burst) >> 2;
            e.id   = 4'(id);
            e.last = (i == len);
            if (widx >= MEM_DEPTH) begin
                e.data = 32'h0;
                e.resp = 2'b10;
            end else begin
                e.data = ref_mem[widx];
                e.resp = bad ? 2'b10 : 2'b00;
            end
            r_q.push_back(e);
        end
        bus.ar_id    = 4'(id);
        bus.ar_addr  = 12'(addr);
        bus.ar_len   = 8'(len);
        bus.ar_size  = 3'(size);
        bus.ar_burst = 2'(burst);
        bus.ar_valid = 1'b1;
        ok = 0;
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            if (bus.ar_ready) begin ok = 1; break; end
        end
        check_handshake("ar_handshake", ok);
        @(posedge clk); #1;
        bus.ar_valid = 1'b0;
        ok = 0;
        for (int t = 0; t < 400; t++) begin
            @(negedge clk);
            if (r_q.size() == 0) begin ok = 1; break; end
        end
        check_handshake("r_burst_done", ok);
        @(posedge clk); #1;
    endtask

    task automatic apply_stimulus(input int id, input int addr, input int len, input int size, input int burst);
        int early;
        for (int i = 0; i < 16; i++) begin
            wdata_tab[i] = $urandom;
            wstrb_tab[i] = 4'($urandom_range(0, 15));
        end
        early = -1;
        if (len > 0 && $urandom_range(0, 7) == 0) early = $urandom_range(0, len - 1);
        write_burst(id, addr, len, size, burst, early, -1);
        read_burst(15 - id, addr, len, size, burst);
    endtask

    // b_ready: random backpressure on the response channel.
    initial begin
        bus.b_ready = 1'b0;
        forever begin
            @(posedge clk); #1;
            bus.b_ready = ($urandom_range(0, 3) != 0);
        end
    end

    // r_ready: random, or the fixed 1-0-0-1 pattern when rr_mode is set.
    initial begin
        bus.r_ready = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (rr_mode) begin
                bus.r_ready = rr_pat[rr_idx];
                rr_idx = (rr_idx + 1) % 4;
            end else begin
                bus.r_ready = ($urandom_range(0, 3) != 0);
            end
        end
    end

    // Monitor: pops expected responses on every handshake and checks that a
    // stalled R beat holds its contents.
    b_exp_t      mon_b;
    r_exp_t      mon_r;
    logic [38:0] mon_cur;
    logic [38:0] mon_held;
    bit          mon_stalled = 0;
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                mon_stalled = 0;
            end else begin
                if (bus.b_valid && bus.b_ready) begin
                    if (b_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("[TB] FAIL b_unexpected: got id=%0d resp=%0d, expected no response", bus.b_id, bus.b_resp);
                    end else begin
                        mon_b = b_q.pop_front();
                        check_output("b_id", 64'(bus.b_id), 64'(mon_b.id));
                        check_output("b_resp", 64'(bus.b_resp), 64'(mon_b.resp));
                    end
                end
                if (bus.r_valid) begin
                    mon_cur = {bus.r_id, bus.r_data, bus.r_resp, bus.r_last};
                    if (mon_stalled) check_output("r_stable", 64'(mon_cur), 64'(mon_held));
                    if (bus.r_ready) begin
                        r_hs++;
                        mon_stalled = 0;
                        if (r_q.size() == 0) begin
                            checks++;
                            errors++;
                            $display("[TB] FAIL r_unexpected: got data=0x%0h, expected no beat", bus.r_data);
                        end else begin
                            mon_r = r_q.pop_front();
                            check_output("r_id", 64'(bus.r_id), 64'(mon_r.id));
                            check_output("r_data", 64'(bus.r_data), 64'(mon_r.data));
                            check_output("r_resp", 64'(bus.r_resp), 64'(mon_r.resp));
                            check_output("r_last", 64'(bus.r_last), 64'(mon_r.last));
                        end
                    end else begin
                        mon_stalled = 1;
                        mon_held = mon_cur;
                    end
                end else begin
                    mon_stalled = 0;
                end
            end
        end
    end

    initial begin
        #2_000_000;
        errors++;
        $display("[TB] FAIL watchdog: got simulation still running, expected completion");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    int hs0;
    int rid;
    int raddr;
    int rlen;
    int rsize;
    int rburst;
    int sel;

    initial begin
        bus.aw_valid = 0; bus.aw_id = 0; bus.aw_addr = 0; bus.aw_len = 0; bus.aw_size = 0; bus.aw_burst = 0;
        bus.w_valid = 0; bus.w_data = 0; bus.w_strb = 0; bus.w_last = 0;
        bus.ar_valid = 0; bus.ar_id = 0; bus.ar_addr = 0; bus.ar_len = 0; bus.ar_size = 0; bus.ar_burst = 0;

        // Reset values and the first cycle after release.
        #2 rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_output("rst_aw_ready", 64'(bus.aw_ready), 64'd0);
        check_output("rst_ar_ready", 64'(bus.ar_ready), 64'd0);
        check_output("rst_w_ready", 64'(bus.w_ready), 64'd0);
        check_output("rst_b_valid", 64'(bus.b_valid), 64'd0);
        check_output("rst_r_valid", 64'(bus.r_valid), 64'd0);
        check_output("rst_r_last", 64'(bus.r_last), 64'd0);
        check_output("rst_b_resp_id", 64'({bus.b_resp, bus.b_id}), 64'd0);
        check_output("rst_r_resp_id", 64'({bus.r_resp, bus.r_id}), 64'd0);
        check_output("rst_r_data", 64'(bus.r_data), 64'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        check_output("post_rst_aw_ready", 64'(bus.aw_ready), 64'd1);
        check_output("post_rst_ar_ready", 64'(bus.ar_ready), 64'd1);

        // Fill the RAM with known contents.
        for (int k = 0; k < 16; k++) begin
            for (int i = 0; i < 16; i++) begin
                wdata_tab[i] = $urandom;
                wstrb_tab[i] = 4'hF;
            end
            write_burst(1, k * 64, 15, 2, 1, -1, -1);
        end

        // INCR write then read back.
        for (int i = 0; i < 4; i++) begin
            wdata_tab[i] = 32'hA0 + i;
            wstrb_tab[i] = 4'hF;
        end
        write_burst(5, 12'h010, 3, 2, 1, -1, -1);
        read_burst(5, 12'h010, 3, 2, 1);

        // WRAP read, legal and illegal length.
        for (int i = 0; i < 4; i++) begin
            wdata_tab[i] = 32'h11 * (i + 1);
            wstrb_tab[i] = 4'hF;
        end
        write_burst(2, 12'h000, 3, 2, 1, -1, -1);
        read_burst(2, 12'h008, 3, 2, 2);
        read_burst(3, 12'h008, 2, 2, 2);

        // Read backpressure with r_ready 1-0-0-1.
        rr_idx = 0;
        rr_mode = 1;
        hs0 = r_hs;
        read_burst(4, 12'h100, 7, 2, 1);
        check_output("r_handshake_count", 64'(r_hs - hs0), 64'd8);
        rr_mode = 0;

        // Out-of-range write must not alias into the array.
        wdata_tab[0] = 32'hDEADBEEF;
        wstrb_tab[0] = 4'hF;
        write_burst(6, 12'h400, 0, 2, 1, -1, -1);
        read_burst(6, 12'h000, 0, 2, 1);
        read_burst(6, 12'h400, 0, 2, 1);

        // Early w_last on beat 1.
        for (int i = 0; i < 4; i++) begin
            wdata_tab[i] = 32'hC0 + i;
            wstrb_tab[i] = 4'hF;
        end
        write_burst(7, 12'h080, 3, 2, 1, 1, -1);
        read_burst(7, 12'h080, 3, 2, 1);

        // Read running off the end of the array.
        read_burst(8, 12'h3F8, 3, 2, 1);

        // Byte strobes.
        wdata_tab[0] = 32'h0;
        wstrb_tab[0] = 4'hF;
        write_burst(1, 12'h040, 0, 2, 1, -1, -1);
        wdata_tab[0] = 32'hFFFFFFFF;
        wstrb_tab[0] = 4'b0101;
        write_burst(1, 12'h040, 0, 2, 1, -1, -1);
        read_burst(1, 12'h040, 0, 2, 1);

        // Concurrent write and read bursts to separate regions.
        for (int i = 0; i < 16; i++) begin
            wdata_tab[i] = $urandom;
            wstrb_tab[i] = 4'hF;
        end
        fork
            write_burst(10, 12'h200, 7, 2, 1, -1, -1);
            read_burst(11, 12'h300, 7, 2, 1);
        join
        read_burst(10, 12'h200, 7, 2, 1);

        // Reset in the middle of a write burst.
        for (int i = 0; i < 16; i++) begin
            wdata_tab[i] = $urandom;
            wstrb_tab[i] = 4'hF;
        end
        write_burst(9, 12'h280, 7, 2, 1, -1, 3);
        rst = 1'b1;
        b_q.delete();
        r_q.delete();
        #1;
        check_output("mid_rst_w_ready", 64'(bus.w_ready), 64'd0);
        check_output("mid_rst_aw_ready", 64'(bus.aw_ready), 64'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;
        check_output("abort_b_valid", 64'(bus.b_valid), 64'd0);
        check_output("abort_aw_ready", 64'(bus.aw_ready), 64'd1);
        read_burst(9, 12'h280, 7, 2, 1);

        // Random bursts.
        for (int n = 0; n < 40; n++) begin
            sel    = $urandom_range(0, 9);
            rburst = (sel < 2) ? 0 : (sel < 7) ? 1 : (sel < 9) ? 2 : 3;
            rlen   = $urandom_range(0, 15);
            if (rburst == 2 && $urandom_range(0, 2) != 0) begin
                sel  = $urandom_range(0, 3);
                rlen = (sel == 0) ? 1 : (sel == 1) ? 3 : (sel == 2) ? 7 : 15;
            end
            rsize = $urandom_range(0, 3);
            raddr = $urandom_range(0, 12'h4FF);
            rid   = $urandom_range(0, 15);
            apply_stimulus(rid, raddr, rlen, rsize, rburst);
        end

        repeat (4) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
